// File: rtl/cache_tag_ctrl.sv
// Direct-mapped cache tag lookup/refill controller with flush sweep; sole driver of the tag memory.
// Optional hit/miss statistics counters are enabled by defining CACHE_TAG_CTRL_STATS_EN.
`timescale 1ns/1ps

package cache;
    localparam int CACHE_INDEX_W = 10;
    localparam int CACHE_TAG_W   = 18;

    typedef struct packed {
        logic                   valid;
        logic [CACHE_TAG_W-1:0] tag;
    } cache_tag_t;

    typedef struct packed {
        logic [CACHE_INDEX_W-1:0] index;
        logic                     we;
    } cache_req_t;
endpackage

module cache_tag_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 4,
    parameter int INDEX_W  = 10,
    parameter int TAG_W    = ADDR_W - OFFSET_W - INDEX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ADDR_W-1:0]  req_addr,
    output logic               resp_valid,
    output logic               resp_hit,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [ADDR_W-1:0]  mem_req_addr,
    input  logic               mem_resp_valid,
    input  logic               flush,
    output logic               flush_busy,
    output cache::cache_req_t  tag_req,
    output cache::cache_tag_t  tag_write,
    input  cache::cache_tag_t  tag_read
`ifdef CACHE_TAG_CTRL_STATS_EN
    ,
    output logic [31:0]        stat_hits,
    output logic [31:0]        stat_misses
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL_REQ,
        S_REFILL_WAIT,
        S_UPDATE,
        S_FLUSH
    } state_e;

    localparam int LINE_W = ADDR_W - OFFSET_W;
    localparam logic [INDEX_W-1:0] LAST_INDEX = '1;

    state_e              state_q, state_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [INDEX_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic                flush_pend_q, flush_pend_d;
    logic                hit_rsp_q, hit_rsp_d;

    logic                lookup_hit;
    logic                unused_offset_bits;

    // Only the line address is kept; the byte offset never affects lookup or refill.
    assign unused_offset_bits = ^req_addr[OFFSET_W-1:0];

    assign lookup_hit   = tag_read.valid && (tag_read.tag == line_q[LINE_W-1 -: TAG_W]);
    assign req_ready    = (state_q == S_IDLE) && !flush_pend_q && !flush;
    assign mem_req_addr = {line_q, {OFFSET_W{1'b0}}};

    // NOTE: every output and next-state value gets a default first so no latches are inferred.
    always_comb begin
        state_d       = state_q;
        line_d        = line_q;
        flush_cnt_d   = flush_cnt_q;
        flush_pend_d  = flush_pend_q;
        hit_rsp_d     = 1'b0;
        tag_req.index = line_q[INDEX_W-1:0];
        tag_req.we    = 1'b0;
        tag_write     = '0;
        mem_req_valid = 1'b0;
        flush_busy    = 1'b0;
        resp_valid    = hit_rsp_q;
        resp_hit      = hit_rsp_q;

        // A flush arriving mid-transaction is remembered and served before the next request.
        if (flush && (state_q != S_IDLE) && (state_q != S_FLUSH)) begin
            flush_pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (flush || flush_pend_q) begin
                    flush_pend_d = 1'b0;
                    state_d      = S_FLUSH;
                end else if (req_valid && req_ready) begin
                    line_d  = req_addr[ADDR_W-1:OFFSET_W];
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (lookup_hit) begin
                    hit_rsp_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_REFILL_REQ;
                end
            end
            S_REFILL_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = S_REFILL_WAIT;
                end
            end
            S_REFILL_WAIT: begin
                if (mem_resp_valid) begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                tag_req.we      = 1'b1;
                tag_write.valid = 1'b1;
                tag_write.tag   = line_q[LINE_W-1 -: TAG_W];
                resp_valid      = 1'b1;
                resp_hit        = 1'b0;
                state_d         = S_IDLE;
            end
            S_FLUSH: begin
                flush_busy    = 1'b1;
                tag_req.index = flush_cnt_q;
                tag_req.we    = 1'b1;
                flush_cnt_d   = flush_cnt_q + INDEX_W'(1);
                if (flush_cnt_q == LAST_INDEX) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            line_q       <= '0;
            flush_cnt_q  <= '0;
            flush_pend_q <= 1'b0;
            hit_rsp_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            flush_cnt_q  <= flush_cnt_d;
            flush_pend_q <= flush_pend_d;
            hit_rsp_q    <= hit_rsp_d;
        end
    end

`ifdef CACHE_TAG_CTRL_STATS_EN
    logic [31:0] hits_q, misses_q;

    // Saturating counters; flush deliberately leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (resp_valid) begin
            if (resp_hit) begin
                if (hits_q != 32'hFFFF_FFFF) hits_q <= hits_q + 32'd1;
            end else begin
                if (misses_q != 32'hFFFF_FFFF) misses_q <= misses_q + 32'd1;
            end
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`endif

endmodule
